// File: rtl/plru_set_array_if.sv
// plru_set_array_if
//   Bundles the update, victim-query/response and flush signals of the
//   pseudo-LRU set array. The cache pipeline uses the master side. The
//   replacement controller uses the slave side.
//   Ports (slave view):
//     upd_valid_i / upd_set_i / upd_used_i      : per-set "way used" update
//     req_valid_i / req_ready_o / req_set_i     : victim query handshake
//     req_invalid_i / req_lock_i                : per-way invalid / lock masks
//     resp_valid_o / resp_way_o / resp_idx_o /
//     resp_none_o                               : registered victim response
//     flush_i / busy_o                          : replacement-state sweep
interface plru_set_array_if #(
  parameter int WAYS = 4,
  parameter int SETS = 64
);
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int WAY_W = $clog2(WAYS);

  logic             upd_valid_i;
  logic [SET_W-1:0] upd_set_i;
  logic [WAYS-1:0]  upd_used_i;

  logic             req_valid_i;
  logic             req_ready_o;
  logic [SET_W-1:0] req_set_i;
  logic [WAYS-1:0]  req_invalid_i;
  logic [WAYS-1:0]  req_lock_i;

  logic             resp_valid_o;
  logic [WAYS-1:0]  resp_way_o;
  logic [WAY_W-1:0] resp_idx_o;
  logic             resp_none_o;

  logic             flush_i;
  logic             busy_o;

  modport master (
    output upd_valid_i, upd_set_i, upd_used_i,
    output req_valid_i, req_set_i, req_invalid_i, req_lock_i,
    output flush_i,
    input  req_ready_o,
    input  resp_valid_o, resp_way_o, resp_idx_o, resp_none_o,
    input  busy_o
  );

  modport slave (
    input  upd_valid_i, upd_set_i, upd_used_i,
    input  req_valid_i, req_set_i, req_invalid_i, req_lock_i,
    input  flush_i,
    output req_ready_o,
    output resp_valid_o, resp_way_o, resp_idx_o, resp_none_o,
    output busy_o
  );
endinterface

// File: rtl/plru_set_array.sv
// plru_set_array
//   Tree pseudo-LRU replacement controller holding one PLRU tree per set.
//   Trees use heap node order: node 0 is the root, and the children of node n
//   are nodes 2n+1 and 2n+2. A node bit of 1 means the LRU way is in the
//   upper subtree.
//   Ports:
//     clk   : clock
//     rst_n : asynchronous active-low reset. It clears every tree, the
//             sweep FSM and the response registers.
//     bus   : plru_set_array_if.slave. It carries the update port, the
//             victim query/response port and the flush sweep control.
//   Victim priority:
//     1. the lowest-index unlocked invalid way
//     2. a lock-aware tree walk
//     3. resp_none_o when every way is locked
//   An update and a query to the same set in one cycle see the updated tree.
module plru_set_array #(
  parameter int WAYS = 4,
  parameter int SETS = 64
) (
  input logic               clk,
  input logic               rst_n,
  plru_set_array_if.slave   bus
);

  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int WAY_W = $clog2(WAYS);
  localparam int NODES = WAYS - 1;
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  typedef struct packed {
    logic             none;
    logic [WAY_W-1:0] idx;
  } victim_t;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Index of the lowest set bit. Returns 0 for an all-zero vector.
  function automatic logic [WAY_W-1:0] lowest_way(input logic [WAYS-1:0] v);
    logic [WAY_W-1:0] r;
    r = '0;
    for (int j = WAYS - 1; j >= 0; j--) begin
      if (v[j]) r = WAY_W'(j);
    end
    return r;
  endfunction

  // Mark a way most-recently used. Each node on the way's path is pointed
  // away from it.
  function automatic logic [NODES-1:0] touch_tree(input logic [NODES-1:0] tree,
                                                  input logic [WAY_W-1:0] way);
    logic [NODES-1:0] t;
    logic [NODES-1:0] mask;
    logic [WAY_W-1:0] wsh;
    logic             dir;
    int               node;
    t = tree;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      wsh  = way >> (WAY_W - lvl);
      node = (1 << lvl) - 1 + int'(wsh);
      wsh  = way >> (WAY_W - 1 - lvl);
      dir  = ~wsh[0];
      mask = NODES'(1) << node;
      t    = dir ? (t | mask) : (t & ~mask);
    end
    return t;
  endfunction

  // Choose the victim. At each node the walk follows the node bit. It takes
  // the other child only when every way under the preferred child is locked.
  // The walk starts only when some way is unlocked, so it always ends on an
  // unlocked way.
  function automatic victim_t pick_victim(input logic [NODES-1:0] tree,
                                          input logic [WAYS-1:0]  inv,
                                          input logic [WAYS-1:0]  lock);
    victim_t          v;
    logic [WAYS-1:0]  avail;
    logic [WAYS-1:0]  cand;
    logic [NODES-1:0] tsh;
    logic             all_locked;
    int               prefix;
    int               child;
    int               node;
    v.none = 1'b0;
    v.idx  = '0;
    avail  = ~lock;
    cand   = inv & avail;
    prefix = 0;
    if (avail == '0) begin
      v.none = 1'b1;
    end else if (cand != '0) begin
      v.idx = lowest_way(cand);
    end else begin
      for (int lvl = 0; lvl < WAY_W; lvl++) begin
        node       = (1 << lvl) - 1 + prefix;
        tsh        = tree >> node;
        child      = 2 * prefix + (tsh[0] ? 1 : 0);
        all_locked = 1'b1;
        for (int j = 0; j < WAYS; j++) begin
          if ((j >> (WAY_W - 1 - lvl)) == child) all_locked = all_locked & lock[j];
        end
        if (all_locked) child = child ^ 1;
        prefix = child;
      end
      v.idx = WAY_W'(prefix);
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------
  // Sweep FSM (state register / next state / outputs)
  // ---------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [SET_W-1:0] cnt_reg, cnt_next;
  logic             is_idle;
  logic             sweep_clr;
  logic             req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.flush_i) begin
          state_next = ST_SWEEP;
          cnt_next   = '0;
        end
      end
      ST_SWEEP: begin
        if (cnt_reg == LAST_SET) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + SET_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    is_idle   = (state_reg == ST_IDLE);
    sweep_clr = (state_reg == ST_SWEEP);
    req_ready = is_idle && !bus.flush_i;
  end

  assign bus.req_ready_o = req_ready;
  assign bus.busy_o      = sweep_clr;

  // ---------------------------------------------------------------------
  // Update and query datapath
  // ---------------------------------------------------------------------
  // With a single set there is no meaningful index, so it is forced to 0.
  logic [SET_W-1:0] upd_set_eff;
  logic [SET_W-1:0] req_set_eff;
  logic             upd_apply;
  logic             req_accept;
  logic [WAY_W-1:0] upd_way;
  logic [NODES-1:0] upd_tree_old;
  logic [NODES-1:0] upd_tree_new;
  logic [NODES-1:0] req_tree_mem;
  logic [NODES-1:0] req_tree;
  victim_t          vic;

  logic [SETS-1:0][NODES-1:0] tree_view;

  assign upd_set_eff = (SETS == 1) ? '0 : bus.upd_set_i;
  assign req_set_eff = (SETS == 1) ? '0 : bus.req_set_i;

  // An update is dropped during a sweep. It is still applied in the cycle
  // that starts the sweep.
  assign upd_apply  = is_idle && bus.upd_valid_i && (bus.upd_used_i != '0);
  assign req_accept = bus.req_valid_i && req_ready;
  assign upd_way    = lowest_way(bus.upd_used_i);

  always_comb begin
    upd_tree_old = '0;
    req_tree_mem = '0;
    for (int s = 0; s < SETS; s++) begin
      if (upd_set_eff == SET_W'(s)) upd_tree_old = tree_view[s];
      if (req_set_eff == SET_W'(s)) req_tree_mem = tree_view[s];
    end
  end

  assign upd_tree_new = touch_tree(upd_tree_old, upd_way);

  // Forward the post-update tree when the same set is updated in this cycle.
  assign req_tree = (upd_apply && (upd_set_eff == req_set_eff)) ? upd_tree_new
                                                                : req_tree_mem;
  assign vic      = pick_victim(req_tree, bus.req_invalid_i, bus.req_lock_i);

  // One register per set. The sweep clear takes precedence over an update.
  // Both cannot happen together, because updates are only applied in IDLE.
  for (genvar gi = 0; gi < SETS; gi++) begin : g_set
    logic [NODES-1:0] tree_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tree_reg <= '0;
      end else if (sweep_clr && (cnt_reg == SET_W'(gi))) begin
        tree_reg <= '0;
      end else if (upd_apply && (upd_set_eff == SET_W'(gi))) begin
        tree_reg <= upd_tree_new;
      end
    end

    assign tree_view[gi] = tree_reg;
  end

  // ---------------------------------------------------------------------
  // Registered response. Outputs hold between valid pulses.
  // ---------------------------------------------------------------------
  logic             resp_valid_reg;
  logic [WAYS-1:0]  resp_way_reg;
  logic [WAY_W-1:0] resp_idx_reg;
  logic             resp_none_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_reg <= 1'b0;
      resp_way_reg   <= '0;
      resp_idx_reg   <= '0;
      resp_none_reg  <= 1'b0;
    end else begin
      resp_valid_reg <= req_accept;
      if (req_accept) begin
        resp_none_reg <= vic.none;
        resp_idx_reg  <= vic.none ? '0 : vic.idx;
        resp_way_reg  <= vic.none ? '0 : (WAYS'(1) << vic.idx);
      end
    end
  end

  assign bus.resp_valid_o = resp_valid_reg;
  assign bus.resp_way_o   = resp_way_reg;
  assign bus.resp_idx_o   = resp_idx_reg;
  assign bus.resp_none_o  = resp_none_reg;

  // The used-way mask must be one-hot or zero. The datapath applies the
  // lowest set bit regardless.
  a_upd_onehot : assert property (@(posedge clk) disable iff (!rst_n)
                                  bus.upd_valid_i |-> $onehot0(bus.upd_used_i));

endmodule

// File: tb/tb_plru_set_array.sv
// tb_plru_set_array
//   Directed bench for plru_set_array (WAYS=4, SETS=64).
//   Stimulus tasks push the expected response into a scoreboard queue. A
//   monitor pops an entry for every resp_valid_o pulse and compares it.
//   Status checks cover reset values, req_ready_o and busy_o.
module tb_plru_set_array;

  localparam int WAYS = 4;
  localparam int SETS = 64;

  typedef struct {
    string      tag;
    logic [3:0] way;
    logic [1:0] idx;
    logic       none;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  plru_set_array_if #(.WAYS(WAYS), .SETS(SETS)) bus();

  plru_set_array #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor. Responses are sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid_o) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp got way=%b idx=%0d none=%b required no response",
                 bus.resp_way_o, bus.resp_idx_o, bus.resp_none_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (bus.resp_way_o !== e.way || bus.resp_idx_o !== e.idx || bus.resp_none_o !== e.none) begin
          failures++;
          $display("FAIL %s got way=%b idx=%0d none=%b required way=%b idx=%0d none=%b",
                   e.tag, bus.resp_way_o, bus.resp_idx_o, bus.resp_none_o, e.way, e.idx, e.none);
        end else begin
          $display("ok   %s way=%b idx=%0d none=%b", e.tag, bus.resp_way_o, bus.resp_idx_o,
                   bus.resp_none_o);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0h required %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic idle_inputs();
    bus.upd_valid_i   = 1'b0;
    bus.upd_set_i     = '0;
    bus.upd_used_i    = '0;
    bus.req_valid_i   = 1'b0;
    bus.req_set_i     = '0;
    bus.req_invalid_i = '0;
    bus.req_lock_i    = '0;
    bus.flush_i       = 1'b0;
  endtask

  task automatic push_exp(input string tag, input logic [3:0] way, input logic [1:0] idx,
                          input logic none);
    exp_t e;
    e.tag  = tag;
    e.way  = way;
    e.idx  = idx;
    e.none = none;
    sb_q.push_back(e);
  endtask

  // One-cycle update.
  task automatic upd(input logic [5:0] set, input logic [3:0] used);
    bus.upd_valid_i = 1'b1;
    bus.upd_set_i   = set;
    bus.upd_used_i  = used;
    @(posedge clk); #1;
    bus.upd_valid_i = 1'b0;
    bus.upd_used_i  = '0;
  endtask

  // One-cycle query. The expected response is queued at issue time.
  task automatic query(input string tag, input logic [5:0] set, input logic [3:0] inv,
                       input logic [3:0] lock, input logic [3:0] ew, input logic [1:0] ei,
                       input logic en);
    push_exp(tag, ew, ei, en);
    bus.req_valid_i   = 1'b1;
    bus.req_set_i     = set;
    bus.req_invalid_i = inv;
    bus.req_lock_i    = lock;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int busy_cnt;
  logic ready_bad;

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_resp_valid", bus.resp_valid_o, 0);
    chk("rst_resp_way", bus.resp_way_o, 0);
    chk("rst_resp_idx", bus.resp_idx_o, 0);
    chk("rst_resp_none", bus.resp_none_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("ready_idle", bus.req_ready_o, 1);

    // Basic tree behaviour and set independence.
    query("q5_reset", 6'd5, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0);
    upd(6'd5, 4'b0001);
    query("q5_after_w0", 6'd5, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0);
    upd(6'd5, 4'b0100);
    // Back-to-back queries.
    query("q5_after_w2", 6'd5, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b0);
    query("q6_indep", 6'd6, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0);
    settle();
    chk("resp_hold_way", bus.resp_way_o, 4'b0001);

    // Locks, no-victim case, invalid-first priority.
    do_reset();
    query("lock_w0", 6'd0, 4'b0000, 4'b0001, 4'b0010, 2'd1, 1'b0);
    query("lock_all", 6'd0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b1);
    query("inv_first", 6'd0, 4'b1010, 4'b0010, 4'b1000, 2'd3, 1'b0);
    upd(6'd8, 4'b0001);
    // Tree of set 8 is now root=1, node1=1. Way 2 is locked, so the walk goes to way 3.
    query("lock_walk", 6'd8, 4'b0000, 4'b0100, 4'b1000, 2'd3, 1'b0);

    // Same-cycle update and query: forwarded to the same set, not to a different one.
    bus.upd_valid_i = 1'b1; bus.upd_set_i = 6'd3; bus.upd_used_i = 4'b0001;
    query("fwd_same_set", 6'd3, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0);
    bus.upd_valid_i = 1'b1; bus.upd_set_i = 6'd9; bus.upd_used_i = 4'b0001;
    query("fwd_other_set", 6'd10, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0);
    settle();

    // Flush sweep.
    upd(6'd0, 4'b0001);
    upd(6'd63, 4'b0001);
    query("dirty_63", 6'd63, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0);
    settle();
    // A flush cycle with a concurrent query (refused) and update (applied).
    bus.flush_i       = 1'b1;
    bus.req_valid_i   = 1'b1;
    bus.req_set_i     = 6'd2;
    bus.upd_valid_i   = 1'b1;
    bus.upd_set_i     = 6'd1;
    bus.upd_used_i    = 4'b0001;
    #1;
    chk("ready_during_flush", bus.req_ready_o, 0);
    @(posedge clk); #1;
    bus.flush_i     = 1'b0;
    bus.upd_valid_i = 1'b0;
    busy_cnt  = 0;
    ready_bad = 1'b0;
    // req_valid_i stays high during the sweep. Any accepted query would
    // show up at the monitor as an unexpected response.
    for (int c = 0; c < 200 && bus.busy_o; c++) begin
      busy_cnt++;
      if (bus.req_ready_o) ready_bad = 1'b1;
      if (c == 10) begin
        bus.upd_valid_i = 1'b1;
        bus.upd_set_i   = 6'd0;
        bus.upd_used_i  = 4'b0001;
      end else begin
        bus.upd_valid_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.req_valid_i = 1'b0;
    bus.upd_valid_i = 1'b0;
    chk("busy_cycles", busy_cnt, 64);
    chk("ready_low_in_sweep", ready_bad, 0);
    query("flushed_0", 6'd0, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0);
    query("flushed_1", 6'd1, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0);
    query("flushed_63", 6'd63, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0);
    settle();

    // Asynchronous reset in the middle of a sweep.
    upd(6'd50, 4'b0001);
    query("dirty_50", 6'd50, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0);
    settle();
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_busy", bus.busy_o, 0);
    chk("async_resp_valid", bus.resp_valid_o, 0);
    chk("async_resp_way", bus.resp_way_o, 0);
    chk("async_ready", bus.req_ready_o, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    query("after_rst_50", 6'd50, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0);
    settle();

    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/plru_set_array.md
Name: plru_set_array

Overview:
- Multi-set tree pseudo-LRU replacement controller for set-associative caches and TLBs. One PLRU tree is held per set.
- Per-way update and victim query ports are indexed by set.
- The victim walk skips locked ways and takes invalid ways first.
- A sequenced flush clears the replacement state one set per cycle, modelling SRAM-style state storage.
- Sits beside the tag array in the cache/TLB pipeline, between the tag-compare stage and the refill logic.

Parameters:
- WAYS, 4, associativity; power of two, >= 2.
- SETS, 64, number of sets; >= 1.
- SET_W, $clog2(SETS) (minimum 1), width of the set index.
- WAY_W, $clog2(WAYS), width of the binary way index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- upd_valid_i  in  1  an update is presented this cycle.
- upd_set_i  in  SET_W  set to update.
- upd_used_i  in  WAYS  way that was used; one-hot or zero.
- req_valid_i  in  1  victim query presented.
- req_ready_o  out  1  query accepted when high.
- req_set_i  in  SET_W  set to query.
- req_invalid_i  in  WAYS  per-way invalid flags for the queried set.
- req_lock_i  in  WAYS  per-way lock/pin mask; locked ways are never chosen.
- resp_valid_o  out  1  response valid, one cycle after acceptance.
- resp_way_o  out  WAYS  one-hot victim way.
- resp_idx_o  out  WAY_W  binary victim index.
- resp_none_o  out  1  every way is locked; no victim exists.
- flush_i  in  1  pulse that starts the state-clear sweep.
- busy_o  out  1  flush sweep in progress.

Behaviour:
- State: SETS trees of WAYS-1 bits each. Node numbering is heap order: node 0 is the root; the children of node n are 2n+1 and 2n+2.
  - At level lvl, the node on way i's path is (2^lvl - 1) + (i >> (WAY_W - lvl)).
  - A node bit of 1 means the upper subtree holds the LRU way.
- Reset (async, rst_n low): all tree bits 0; FSM in IDLE; busy_o=0; resp_valid_o=0; resp_way_o=0; resp_idx_o=0; resp_none_o=0.
- Update (IDLE, upd_valid_i=1, upd_used_i nonzero):
  - On the clock edge, every node on used way i's path is set to the inverse of i's bit at that level.
  - Nodes off the path are unchanged.
  - upd_used_i=0 is a no-op.
  - A non-one-hot upd_used_i is illegal and is flagged by a simulation assertion; RTL applies the lowest set bit.
- Query:
  - req_ready_o = (state==IDLE) && !flush_i.
  - A query is accepted when req_valid_i && req_ready_o; the response is registered and valid the next cycle.
  - resp_valid_o is a one-cycle pulse per accepted query; back-to-back queries are allowed every cycle.
  - Response outputs hold their last value when resp_valid_o=0.
- Victim priority:
  - 1) The lowest-index way with invalid=1 and lock=0.
  - 2) Otherwise, a lock-aware tree walk from the root. At each node, follow the node bit unless every way in that subtree is locked; in that case take the other child.
  - 3) If all ways are locked: resp_none_o=1, resp_way_o=0, resp_idx_o=0.
- Forwarding: an update and a query to the same set in the same accepted cycle are answered from the post-update tree. Different sets are independent.
- Flush FSM (IDLE -> SWEEP -> IDLE):
  - flush_i in IDLE enters SWEEP with counter=0. busy_o=1 from the next cycle.
  - Each SWEEP cycle clears set[counter] and increments the counter. The sweep leaves SWEEP after clearing set SETS-1, so busy_o is high for exactly SETS cycles.
  - In SWEEP: updates are dropped, req_ready_o=0, and flush_i is ignored.
  - A query presented in the same cycle as flush_i is not accepted. An update in that same cycle is applied.
- Reset mid-sweep: returns immediately to IDLE with all state cleared.
- SETS=1: the set index is ignored; the sweep takes 1 cycle.

Test Plan:
- WAYS=4; after reset, query set 5 with invalid=0, lock=0 -> next cycle resp_valid_o=1, resp_way_o=0001, resp_idx_o=0, resp_none_o=0.
- Update set 5 with used=0001, then query set 5 -> resp_way_o=0100. Update used=0100, then query -> resp_way_o=0010. Query set 6 -> 0001 (sets are independent).
- After reset, query with lock=0001 -> resp_way_o=0010. Lock=1111 -> resp_none_o=1, resp_way_o=0000. Invalid=1010 with lock=0010 -> resp_way_o=1000.
- Same cycle: update set 3 with used=0001 plus query set 3 -> resp_way_o=0100 (forwarded post-update state).
- With SETS=64 and dirty state in sets 0 and 63: pulse flush_i -> busy_o high for exactly 64 cycles, req_ready_o low throughout, an update issued mid-sweep is dropped; afterwards a query of any set -> resp_way_o=0001.
- Assert rst_n low for 1 cycle mid-sweep -> busy_o=0 and resp_valid_o=0 immediately (asynchronously). The next query returns 0001.
